// File: rtl/nn_pkg.sv
// Shared network definitions: output-layer geometry, score type and the
// argmax scanner state encoding.
package nn_pkg;

    localparam int N_CLASS = 10;
    localparam int DW      = 16;
    localparam int IDX_W   = $clog2(N_CLASS);
    localparam int CNT_W   = 16;

    // Signed two's complement neuron score, shared with the network top.
    typedef logic signed [DW-1:0] score_t;
    typedef logic [IDX_W-1:0]     idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Most negative score; seeds the runner-up so any lane beats it.
    localparam score_t SCORE_MIN = {1'b1, {(DW-1){1'b0}}};

    // best - second at DW+1 bits, saturated into an unsigned DW-bit margin.
    // The DW+1 bit difference of two DW-bit signed values never exceeds
    // 2^DW-1, so the upper clamp is implicit; a negative difference (not
    // possible while best >= second) is forced to 0 for safety.
    function automatic logic [DW-1:0] margin_sat(input score_t best, input score_t second);
        logic [DW:0] diff;
        diff = {best[DW-1], best} - {second[DW-1], second};
        if (diff[DW]) begin
            margin_sat = '0;
        end else begin
            margin_sat = diff[DW-1:0];
        end
    endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Combinational signed compare/update cell for the serial argmax scan.
// With CLASS_ARGMAX_MARGIN_EN defined it also tracks the runner-up score.
module argmax_cmp
    import nn_pkg::*;
(
    input  logic signed [DW-1:0] lane,
    input  logic signed [DW-1:0] best,
`ifdef CLASS_ARGMAX_MARGIN_EN
    input  logic signed [DW-1:0] second,
    output logic signed [DW-1:0] second_nxt,
`endif
    input  logic [IDX_W-1:0]     ptr,
    input  logic [IDX_W-1:0]     idx,
    output logic signed [DW-1:0] best_nxt,
    output logic [IDX_W-1:0]     idx_nxt
);

    // Strictly greater replaces best, so ties keep the lower index.
    always_comb begin
        best_nxt   = best;
        idx_nxt    = idx;
`ifdef CLASS_ARGMAX_MARGIN_EN
        second_nxt = second;
`endif
        if (lane > best) begin
            best_nxt   = lane;
            idx_nxt    = ptr;
`ifdef CLASS_ARGMAX_MARGIN_EN
            second_nxt = best;
        end else if (lane > second) begin
            second_nxt = lane;
`endif
        end
    end

endmodule

// File: rtl/class_argmax.sv
// Output-layer argmax: captures N_CLASS scores on a strobe, scans them one
// lane per clock and holds the winning class under a valid/ack handshake.
// Optional feature macro: CLASS_ARGMAX_MARGIN_EN (runner-up margin output).
module class_argmax
    import nn_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CLASS*DW-1:0] scores_in,
    input  logic                  scores_valid,
    input  logic                  result_ack,
    output logic [IDX_W-1:0]      class_idx,
    output logic [DW-1:0]         max_score,
    output logic [DW-1:0]         margin,
    output logic                  result_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic [CNT_W-1:0]      class_count
);

    localparam logic [IDX_W-1:0] LAST_PTR  = IDX_W'(N_CLASS - 1);
    localparam logic [IDX_W-1:0] FIRST_PTR = IDX_W'(1);

    state_t                state_q, state_d;
    logic signed [DW-1:0]  lane_q [N_CLASS];
    logic signed [DW-1:0]  lane_d [N_CLASS];
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic signed [DW-1:0]  best_q, best_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  rv_q, rv_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [IDX_W-1:0]      class_idx_q, class_idx_d;
    logic [DW-1:0]         max_score_q, max_score_d;
    logic                  capture;
    logic signed [DW-1:0]  cmp_best;
    logic [IDX_W-1:0]      cmp_idx;
`ifdef CLASS_ARGMAX_MARGIN_EN
    logic signed [DW-1:0]  second_q, second_d;
    logic signed [DW-1:0]  cmp_second;
    logic [DW-1:0]         margin_q, margin_d;
`endif

    // Shadow score registers: load every lane when a frame is accepted.
    genvar gi;
    generate
        for (gi = 0; gi < N_CLASS; gi++) begin : g_lane
            assign lane_d[gi] = capture ? scores_in[gi*DW +: DW] : lane_q[gi];

            // Per-lane shadow flop.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    lane_q[gi] <= '0;
                end else begin
                    lane_q[gi] <= lane_d[gi];
                end
            end
        end
    endgenerate

    argmax_cmp u_cmp (
        .lane       (lane_q[ptr_q]),
        .best       (best_q),
`ifdef CLASS_ARGMAX_MARGIN_EN
        .second     (second_q),
        .second_nxt (cmp_second),
`endif
        .ptr        (ptr_q),
        .idx        (idx_q),
        .best_nxt   (cmp_best),
        .idx_nxt    (cmp_idx)
    );

    // Next-state, scan datapath and handshake/status updates.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        best_d      = best_q;
        idx_d       = idx_q;
        rv_d        = rv_q;
        overrun_d   = overrun_q;
        count_d     = count_q;
        class_idx_d = class_idx_q;
        max_score_d = max_score_q;
        capture     = 1'b0;
`ifdef CLASS_ARGMAX_MARGIN_EN
        second_d    = second_q;
        margin_d    = margin_q;
`endif

        case (state_q)
            IDLE: begin
                if (scores_valid) begin
                    capture = 1'b1;
                end
            end
            SCAN: begin
                // A frame arriving mid-scan has nowhere to go.
                if (scores_valid) begin
                    overrun_d = 1'b1;
                end
                best_d = cmp_best;
                idx_d  = cmp_idx;
`ifdef CLASS_ARGMAX_MARGIN_EN
                second_d = cmp_second;
`endif
                if (ptr_q == LAST_PTR) begin
                    state_d     = HOLD;
                    rv_d        = 1'b1;
                    count_d     = count_q + CNT_W'(1);
                    class_idx_d = cmp_idx;
                    max_score_d = cmp_best;
`ifdef CLASS_ARGMAX_MARGIN_EN
                    margin_d    = margin_sat(cmp_best, cmp_second);
`endif
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            HOLD: begin
                if (result_ack) begin
                    rv_d = 1'b0;
                    // Ack plus a new strobe chains straight into the next scan.
                    if (scores_valid) begin
                        capture = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (scores_valid) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Frame capture seeds the scan with lane 0 as the current best.
        if (capture) begin
            state_d = SCAN;
            best_d  = scores_in[DW-1:0];
            idx_d   = '0;
            ptr_d   = FIRST_PTR;
`ifdef CLASS_ARGMAX_MARGIN_EN
            second_d = SCORE_MIN;
`endif
        end

        busy_d = (state_d != IDLE);
    end

    // State, scan and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            best_q      <= '0;
            idx_q       <= '0;
            rv_q        <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            count_q     <= '0;
            class_idx_q <= '0;
            max_score_q <= '0;
`ifdef CLASS_ARGMAX_MARGIN_EN
            second_q    <= '0;
            margin_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            best_q      <= best_d;
            idx_q       <= idx_d;
            rv_q        <= rv_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            count_q     <= count_d;
            class_idx_q <= class_idx_d;
            max_score_q <= max_score_d;
`ifdef CLASS_ARGMAX_MARGIN_EN
            second_q    <= second_d;
            margin_q    <= margin_d;
`endif
        end
    end

    assign class_idx    = class_idx_q;
    assign max_score    = max_score_q;
    assign result_valid = rv_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;
    assign class_count  = count_q;
`ifdef CLASS_ARGMAX_MARGIN_EN
    assign margin       = margin_q;
`else
    assign margin       = '0;
`endif

endmodule
